// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Brief    : Round-robin sharing of one I2C master among REQ_N requesters.
//            Optional watchdog recovery is enabled by defining I2C_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module i2c_bus_arbiter #(
    parameter int REQ_N       = 4,
    parameter int REQ_BIT_WID = 2,
    parameter int WR_BYTES    = 2,
    parameter int RD_BYTES    = 2,
    parameter int LEN_WID     = 2,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_N-1:0]               req_start,
    input  logic [REQ_N*7-1:0]             req_addr,
    input  logic [REQ_N*WR_BYTES*8-1:0]    req_wr_buf,
    input  logic [REQ_N*LEN_WID-1:0]       req_wr_len,
    input  logic [REQ_N*LEN_WID-1:0]       req_rd_len,
    output logic [REQ_N-1:0]               req_busy,
    output logic [REQ_N-1:0]               req_done,
    output logic [REQ_N-1:0]               req_err,
    output logic [RD_BYTES*8-1:0]          rd_data,
    output logic [REQ_BIT_WID-1:0]         grant,
    output logic [6:0]                     m_addr,
    output logic [WR_BYTES*8-1:0]          m_wr_buf,
    output logic [LEN_WID-1:0]             m_wr_len,
    output logic [LEN_WID-1:0]             m_rd_len,
    output logic                           m_start,
    output logic                           m_rst,
    input  logic                           m_done,
    input  logic                           m_err_line,
    input  logic                           m_err_nack,
    input  logic [RD_BYTES*8-1:0]          m_rd_buf
);

    localparam logic [REQ_BIT_WID-1:0] c_LAST_INIT = REQ_BIT_WID'(REQ_N - 1);
    localparam logic [REQ_BIT_WID:0]   c_REQ_N     = (REQ_BIT_WID + 1)'(REQ_N);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_REPORT  = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [REQ_N-1:0]         r_pending;
    logic [REQ_N-1:0]         w_grant_oh;
    logic [REQ_BIT_WID-1:0]   r_grant;
    logic [REQ_BIT_WID-1:0]   r_last;
    logic [REQ_BIT_WID-1:0]   w_pick;
    logic [REQ_BIT_WID-1:0]   w_idx;
    logic [REQ_BIT_WID:0]     w_sum;
    logic                     w_found;
    logic                     r_done_hit;
    logic                     w_done_now;
    logic                     r_err;
    logic [RD_BYTES*8-1:0]    r_rd_data;
    logic [6:0]               r_m_addr;
    logic [WR_BYTES*8-1:0]    r_m_wr_buf;
    logic [LEN_WID-1:0]       r_m_wr_len;
    logic [LEN_WID-1:0]       r_m_rd_len;

    assign w_grant_oh = REQ_N'(1) << r_grant;
    assign w_done_now = (r_state == S_WAIT) && m_done && !r_done_hit;

    // First pending index searching upward from last+1, wrapping at REQ_N
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= REQ_N; k++) begin
            w_sum = {1'b0, r_last} + (REQ_BIT_WID + 1)'(k);
            if (w_sum >= c_REQ_N) begin
                w_sum = w_sum - c_REQ_N;
            end
            w_idx = w_sum[REQ_BIT_WID-1:0];
            if (!w_found && r_pending[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic [3:0]  r_rec_cnt;
    logic        w_timeout;
    logic        w_rec_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_rec_cnt <= '0;
        end else begin
            r_wd_cnt  <= (r_state == S_WAIT)    ? r_wd_cnt + 32'd1  : '0;
            r_rec_cnt <= (r_state == S_RECOVER) ? r_rec_cnt + 4'd1 : '0;
        end
    end

    // A completion seen in the timeout cycle wins and finishes normally
    assign w_timeout  = (r_state == S_WAIT) && (r_wd_cnt == 32'(TIMEOUT_CYC - 1))
                        && !m_done && !r_done_hit;
    assign w_rec_done = (r_rec_cnt == 4'd15);
    assign m_rst      = (r_state == S_RECOVER);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(32'(TIMEOUT_CYC));
    assign m_rst            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_grant    <= '0;
            r_last     <= c_LAST_INIT;
            r_done_hit <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            r_m_addr   <= '0;
            r_m_wr_buf <= '0;
            r_m_wr_len <= '0;
            r_m_rd_len <= '0;
        end else begin
            r_state    <= w_next;
            r_pending  <= (r_pending & ~req_done) | req_start;
            r_done_hit <= w_done_now;
            if (r_state == S_ARB) begin
                r_grant    <= w_pick;
                r_last     <= w_pick;
                r_m_addr   <= req_addr[w_pick*7 +: 7];
                r_m_wr_buf <= req_wr_buf[w_pick*(WR_BYTES*8) +: WR_BYTES*8];
                r_m_wr_len <= req_wr_len[w_pick*LEN_WID +: LEN_WID];
                r_m_rd_len <= req_rd_len[w_pick*LEN_WID +: LEN_WID];
            end
            if (w_done_now) begin
                r_rd_data <= m_rd_buf;
                r_err     <= m_err_line | m_err_nack;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            if ((r_state == S_RECOVER) && w_rec_done) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_next   = r_state;
        req_done = '0;
        req_err  = '0;
        m_start  = 1'b0;
        case (r_state)
            S_IDLE:   if (|r_pending) w_next = S_ARB;
            S_ARB:    w_next = S_LAUNCH;
            S_LAUNCH: begin
                m_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (r_done_hit) begin
                    w_next = S_REPORT;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next = S_RECOVER;
`endif
                end
            end
            S_REPORT: begin
                req_done = w_grant_oh;
                req_err  = r_err ? w_grant_oh : '0;
                w_next   = S_IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            S_RECOVER: if (w_rec_done) w_next = S_REPORT;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    assign req_busy = r_pending;
    assign grant    = r_grant;
    assign rd_data  = r_rd_data;
    assign m_addr   = r_m_addr;
    assign m_wr_buf = r_m_wr_buf;
    assign m_wr_len = r_m_wr_len;
    assign m_rd_len = r_m_rd_len;

endmodule
`default_nettype wire
